// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_stage
//  Description : Elastic valid/ready pipeline stage carrying a data and a
//                control payload. Has an optional 2-entry skid slot, a flush
//                that turns the stage into a bubble, and a safe bubble
//                encoding on the control field.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          CTRL_W      = 16,
    parameter logic [CTRL_W-1:0]    CTRL_BUBBLE = '0,
    parameter bit                   SKID_EN     = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [CTRL_W-1:0]   i_ctrl,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_W-1:0]   o_data,
    output logic [CTRL_W-1:0]   o_ctrl,
    output logic [1:0]          o_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] c_DATA_ZERO = '0;

    state_t              r_state_q,     w_state_d;
    logic                r_valid_q,     w_valid_d;
    logic [1:0]          r_count_q,     w_count_d;
    logic [DATA_W-1:0]   r_main_data_q, w_main_data_d;
    logic [CTRL_W-1:0]   r_main_ctrl_q, w_main_ctrl_d;
    logic [DATA_W-1:0]   r_skid_data_q, w_skid_data_d;
    logic [CTRL_W-1:0]   r_skid_ctrl_q, w_skid_ctrl_d;

    logic w_ready;
    logic w_push;
    logic w_pop;

    // With the skid slot, o_ready depends only on flops (plus rst/flush gating),
    // which breaks the combinational ready path back to upstream.
    generate
        if (SKID_EN) begin : g_ready_skid
            assign w_ready = !i_rst && !i_flush && (r_state_q != ST_SKID);
        end else begin : g_ready_single
            assign w_ready = !i_rst && !i_flush && (!r_valid_q || i_ready);
        end
    endgenerate

    assign w_push = i_valid && w_ready;
    assign w_pop  = r_valid_q && i_ready;

    always_comb begin
        w_state_d     = r_state_q;
        w_main_data_d = r_main_data_q;
        w_main_ctrl_d = r_main_ctrl_q;
        w_skid_data_d = r_skid_data_q;
        w_skid_ctrl_d = r_skid_ctrl_q;

        if (i_flush) begin
            w_state_d     = ST_EMPTY;
            w_main_data_d = c_DATA_ZERO;
            w_main_ctrl_d = CTRL_BUBBLE;
            w_skid_data_d = c_DATA_ZERO;
            w_skid_ctrl_d = CTRL_BUBBLE;
        end else begin
            case (r_state_q)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_d     = ST_FULL;
                        w_main_data_d = i_data;
                        w_main_ctrl_d = i_ctrl;
                    end
                end
                ST_FULL: begin
                    if (w_push && w_pop) begin
                        w_main_data_d = i_data;
                        w_main_ctrl_d = i_ctrl;
                    end else if (w_push) begin
                        // Only reachable with the skid slot: single-register
                        // mode cannot accept without a simultaneous pop.
                        w_state_d     = ST_SKID;
                        w_skid_data_d = i_data;
                        w_skid_ctrl_d = i_ctrl;
                    end else if (w_pop) begin
                        w_state_d     = ST_EMPTY;
                        w_main_data_d = c_DATA_ZERO;
                        w_main_ctrl_d = CTRL_BUBBLE;
                    end
                end
                ST_SKID: begin
                    if (w_pop) begin
                        w_state_d     = ST_FULL;
                        w_main_data_d = r_skid_data_q;
                        w_main_ctrl_d = r_skid_ctrl_q;
                        w_skid_data_d = c_DATA_ZERO;
                        w_skid_ctrl_d = CTRL_BUBBLE;
                    end
                end
                default: begin
                    w_state_d     = ST_EMPTY;
                    w_main_data_d = c_DATA_ZERO;
                    w_main_ctrl_d = CTRL_BUBBLE;
                    w_skid_data_d = c_DATA_ZERO;
                    w_skid_ctrl_d = CTRL_BUBBLE;
                end
            endcase
        end
    end

    always_comb begin
        w_valid_d = (w_state_d != ST_EMPTY);
        case (w_state_d)
            ST_FULL: w_count_d = 2'd1;
            ST_SKID: w_count_d = 2'd2;
            default: w_count_d = 2'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q     <= ST_EMPTY;
            r_valid_q     <= 1'b0;
            r_count_q     <= 2'd0;
            r_main_data_q <= c_DATA_ZERO;
            r_main_ctrl_q <= CTRL_BUBBLE;
            r_skid_data_q <= c_DATA_ZERO;
            r_skid_ctrl_q <= CTRL_BUBBLE;
        end else begin
            r_state_q     <= w_state_d;
            r_valid_q     <= w_valid_d;
            r_count_q     <= w_count_d;
            r_main_data_q <= w_main_data_d;
            r_main_ctrl_q <= w_main_ctrl_d;
            r_skid_data_q <= w_skid_data_d;
            r_skid_ctrl_q <= w_skid_ctrl_d;
        end
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid_q;
    assign o_data  = r_main_data_q;
    assign o_ctrl  = r_main_ctrl_q;
    assign o_count = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_stage
//  Description : Scoreboard bench driving a skid-enabled and a single-register
//                instance of pipe_skid_stage from shared inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

    localparam logic [15:0] c_BUB_A = 16'h0000;
    localparam logic [15:0] c_BUB_B = 16'h0003;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] in_data;
    logic [15:0] in_ctrl;

    logic        a_ready, a_valid, b_ready, b_valid;
    logic [31:0] a_data, b_data;
    logic [15:0] a_ctrl, b_ctrl;
    logic [1:0]  a_count, b_count;

    logic [47:0] qa[$];
    logic [47:0] qb[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(32), .CTRL_W(16), .CTRL_BUBBLE(c_BUB_A), .SKID_EN(1'b1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(a_ready),
        .i_data(in_data), .i_ctrl(in_ctrl), .o_valid(a_valid), .i_ready(in_ready),
        .o_data(a_data), .o_ctrl(a_ctrl), .o_count(a_count));

    pipe_skid_stage #(.DATA_W(32), .CTRL_W(16), .CTRL_BUBBLE(c_BUB_B), .SKID_EN(1'b0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(b_ready),
        .i_data(in_data), .i_ctrl(in_ctrl), .o_valid(b_valid), .i_ready(in_ready),
        .o_data(b_data), .o_ctrl(b_ctrl), .o_count(b_count));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [15:0] c,
                         input logic r, input logic f, input logic rs);
        in_valid = v; in_data = d; in_ctrl = c; in_ready = r; flush = f; rst = rs;
    endtask

    // Record accepted ops, cross the edge, then drop whatever flush/reset discarded.
    task automatic step();
        @(negedge clk);
        if (in_valid && a_ready) qa.push_back({in_data, in_ctrl});
        if (in_valid && b_ready) qb.push_back({in_data, in_ctrl});
        @(posedge clk);
        if (flush || rst) begin
            qa.delete();
            qb.delete();
        end
        #1;
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        drive(v, d, d[15:0] ^ 16'h5A50, r, 1'b0, 1'b0);
        step();
    endtask

    always @(negedge clk) begin
        logic [47:0] e;
        if (a_valid) begin
            if (in_ready) begin
                if (qa.size() == 0) chk("a_unexpected_pop", 64'(a_data), 64'hDEAD);
                else begin
                    e = qa.pop_front();
                    chk("a_sb_data", 64'(a_data), 64'(e[47:16]));
                    chk("a_sb_ctrl", 64'(a_ctrl), 64'(e[15:0]));
                end
            end
        end else begin
            chk("a_idle_ctrl", 64'(a_ctrl), 64'(c_BUB_A));
            chk("a_idle_data", 64'(a_data), 64'h0);
        end
    end

    always @(negedge clk) begin
        logic [47:0] e;
        if (b_valid) begin
            if (in_ready) begin
                if (qb.size() == 0) chk("b_unexpected_pop", 64'(b_data), 64'hDEAD);
                else begin
                    e = qb.pop_front();
                    chk("b_sb_data", 64'(b_data), 64'(e[47:16]));
                    chk("b_sb_ctrl", 64'(b_ctrl), 64'(e[15:0]));
                end
            end
        end else begin
            chk("b_idle_ctrl", 64'(b_ctrl), 64'(c_BUB_B));
        end
        chk("b_count_le1", 64'(b_count <= 2'd1), 64'h1);
    end

    initial begin
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("rst_a_ready", 64'(a_ready), 64'h0);
        step(); step();
        chk("rst_a_valid", 64'(a_valid), 64'h0);
        chk("rst_a_count", 64'(a_count), 64'h0);
        chk("rst_b_ctrl", 64'(b_ctrl), 64'(c_BUB_B));
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("post_rst_a_ready", 64'(a_ready), 64'h1);

        // Streaming at full rate
        cyc(1'b1, 32'd1, 1'b1);
        chk("s1_data", 64'(a_data), 64'd1); chk("s1_count", 64'(a_count), 64'd1);
        cyc(1'b1, 32'd2, 1'b1);
        chk("s2_data", 64'(a_data), 64'd2); chk("s2_count", 64'(a_count), 64'd1);
        cyc(1'b1, 32'd3, 1'b1);
        chk("s3_data", 64'(a_data), 64'd3); chk("s3_valid", 64'(a_valid), 64'd1);
        cyc(1'b0, 32'd0, 1'b1);
        chk("s_drain_valid", 64'(a_valid), 64'd0);

        // Back-pressure fills the skid slot
        cyc(1'b1, 32'hA, 1'b0);
        cyc(1'b1, 32'hB, 1'b0);
        chk("bp_count", 64'(a_count), 64'd2);
        chk("bp_ready", 64'(a_ready), 64'd0);
        chk("bp_data", 64'(a_data), 64'hA);
        cyc(1'b0, 32'h0, 1'b1);
        chk("bp_rel1_data", 64'(a_data), 64'hB); chk("bp_rel1_count", 64'(a_count), 64'd1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("bp_rel2_count", 64'(a_count), 64'd0);

        // Flush while holding two ops with a new op offered
        cyc(1'b1, 32'h11, 1'b0);
        cyc(1'b1, 32'h12, 1'b0);
        chk("fl_pre_count", 64'(a_count), 64'd2);
        drive(1'b1, 32'hC, 16'h00CC, 1'b0, 1'b1, 1'b0);
        #1;
        chk("fl_ready", 64'(a_ready), 64'd0);
        step();
        chk("fl_valid", 64'(a_valid), 64'd0);
        chk("fl_ctrl", 64'(a_ctrl), 64'(c_BUB_A));
        chk("fl_count", 64'(a_count), 64'd0);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);

        // Reset with two ops held
        cyc(1'b1, 32'h21, 1'b0);
        cyc(1'b1, 32'h22, 1'b0);
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("rs_ready_in_rst", 64'(a_ready), 64'd0);
        step();
        chk("rs_valid", 64'(a_valid), 64'd0);
        chk("rs_data", 64'(a_data), 64'd0);
        chk("rs_ctrl", 64'(a_ctrl), 64'(c_BUB_A));
        chk("rs_count", 64'(a_count), 64'd0);
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rs_ready_after", 64'(a_ready), 64'd1);

        // Single-register instance: ready follows downstream ready combinationally
        cyc(1'b1, 32'h31, 1'b0);
        chk("b_full_valid", 64'(b_valid), 64'd1);
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0); #1;
        chk("b_ready_tracks1", 64'(b_ready), 64'd1);
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0); #1;
        chk("b_ready_tracks0", 64'(b_ready), 64'd0);
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0); #1;
        chk("b_ready_tracks1b", 64'(b_ready), 64'd1);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("b_empty_ctrl", 64'(b_ctrl), 64'(c_BUB_B));
        chk("b_empty_count", 64'(b_count), 64'd0);

        // Random valid/ready with occasional flush
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 32'(i + 32'h1000), 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 59) == 0), 1'b0);
            step();
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1);
        chk("end_qa_empty", 64'(qa.size()), 64'd0);
        chk("end_qb_empty", 64'(qb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
